// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared types, instruction field layout and FSM encoding for alu_sequencer
package alu_sequencer_pkg;

   localparam int REG_COUNT = 4;
   localparam int REG_AW    = 2;
   localparam int DATA_W    = 8;
   localparam int INSTR_W   = 16;
   localparam int SEL_W     = 3;

   localparam int CLS_LSB = 14;
   localparam int OP_LSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS_LSB  = 0;

   typedef enum logic [1:0] {
      CLS_ALU_RR = 2'b00,
      CLS_ALU_RI = 2'b01,
      CLS_LOADI  = 2'b10,
      CLS_HALT   = 2'b11
   } instr_class_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_DECODE    = 3'd2,
      S_EXECUTE   = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALTED    = 3'd5
   } state_t;

   function automatic instr_class_t instr_class(input logic [INSTR_W-1:0] instr);
      return instr_class_t'(instr[CLS_LSB +: 2]);
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction fetch handshake and ALU operand/result bundle
interface alu_sequencer_if
   import alu_sequencer_pkg::*;
#(
   parameter int ADDR_W = 8
);
   logic                imem_req;
   logic [ADDR_W-1:0]   imem_addr;
   logic                imem_ack;
   logic [INSTR_W-1:0]  imem_rdata;
   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic [SEL_W-1:0]    alu_sel;
   logic [DATA_W-1:0]   alu_result;
   logic                alu_carry;

   modport master (
      output imem_req, imem_addr, alu_a, alu_b, alu_sel,
      input  imem_ack, imem_rdata, alu_result, alu_carry
   );

   modport slave (
      input  imem_req, imem_addr, alu_a, alu_b, alu_sel,
      output imem_ack, imem_rdata, alu_result, alu_carry
   );
endinterface

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - 4x8 register file: one write port, two operand reads, one debug read
module seq_regfile
   import alu_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   input  logic [REG_AW-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);
   logic [DATA_W-1:0] regs [REG_COUNT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   // Reads are combinational; the sequencer latches operands itself during DECODE.
   assign ra_data  = regs[ra_addr];
   assign rb_data  = regs[rb_addr];
   assign dbg_data = regs[dbg_addr];
endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - fetch/decode/execute/writeback sequencer driving the 8-bit ALU datapath
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int RESET_PC = 0
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   alu_sequencer_if.master    bus,
   output logic               wb_en,
   output logic [DATA_W-1:0]  wb_data,
   output logic               busy,
   output logic               halted,
   output logic               carry_flag,
   input  logic [REG_AW-1:0]  dbg_sel,
   output logic [DATA_W-1:0]  dbg_data
);
   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pc;
   logic [INSTR_W-1:0]  ir;
   logic [DATA_W-1:0]   op_a, op_b, res;
   logic [SEL_W-1:0]    op_sel;
   logic                cry;
   logic                fetch_req;
   instr_class_t        cls;
   logic [REG_AW-1:0]   rd, rs;
   logic [DATA_W-1:0]   imm, rd_val, rs_val;

   assign cls = instr_class(ir);
   assign rd  = ir[RD_LSB +: REG_AW];
   assign rs  = ir[RS_LSB +: REG_AW];
   assign imm = DATA_W'(ir);

   seq_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (wb_en),
      .waddr    (rd),
      .wdata    (res),
      .ra_addr  (rd),
      .ra_data  (rd_val),
      .rb_addr  (rs),
      .rb_data  (rs_val),
      .dbg_addr (dbg_sel),
      .dbg_data (dbg_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      fetch_req = 1'b0;
      busy      = 1'b0;
      halted    = 1'b0;
      wb_en     = 1'b0;
      case (state)
         S_IDLE: if (start) state_nxt = S_FETCH;
         S_FETCH: begin
            fetch_req = 1'b1;
            busy      = 1'b1;
            if (bus.imem_ack) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            busy      = 1'b1;
            state_nxt = (cls == CLS_HALT) ? S_HALTED : S_EXECUTE;
         end
         S_EXECUTE: begin
            busy      = 1'b1;
            state_nxt = S_WRITEBACK;
         end
         S_WRITEBACK: begin
            busy      = 1'b1;
            wb_en     = 1'b1;
            state_nxt = S_FETCH;
         end
         S_HALTED: begin
            halted = 1'b1;
            if (start) state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // PC only advances in WRITEBACK, so a HALT leaves it pointing at itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= PC_INIT;
         ir         <= '0;
         op_a       <= '0;
         op_b       <= '0;
         op_sel     <= '0;
         res        <= '0;
         cry        <= 1'b0;
         carry_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_HALTED: if (start) pc <= PC_INIT;
            S_FETCH: if (bus.imem_ack) ir <= bus.imem_rdata;
            S_DECODE: if (cls != CLS_HALT) begin
               op_a   <= rd_val;
               op_b   <= (cls == CLS_ALU_RR) ? rs_val : imm;
               op_sel <= ir[OP_LSB +: SEL_W];
            end
            S_EXECUTE: begin
               res <= (cls == CLS_LOADI) ? imm : bus.alu_result;
               cry <= bus.alu_carry;
            end
            S_WRITEBACK: begin
               if (cls != CLS_LOADI) carry_flag <= cry;
               pc <= pc + ADDR_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bus.imem_req  = fetch_req;
   assign bus.imem_addr = pc;
   assign bus.alu_a     = op_a;
   assign bus.alu_b     = op_b;
   assign bus.alu_sel   = op_sel;
   assign wb_data       = wb_en ? res : '0;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with ROM/ALU models and a reference CPU model
module tb_alu_sequencer;
   import alu_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, start2;
   logic       wb_en, busy, halted, carry_flag;
   logic [7:0] wb_data, dbg_data;
   logic [1:0] dbg_sel;
   logic       wb_en2, busy2, halted2, carry_flag2;
   logic [7:0] wb_data2, dbg_data2;
   logic [1:0] dbg_sel2;

   alu_sequencer_if #(.ADDR_W(8)) bus ();
   alu_sequencer_if #(.ADDR_W(2)) bus2 ();

   alu_sequencer #(.ADDR_W(8), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus),
      .wb_en(wb_en), .wb_data(wb_data), .busy(busy), .halted(halted),
      .carry_flag(carry_flag), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   alu_sequencer #(.ADDR_W(2), .RESET_PC(3)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bus(bus2),
      .wb_en(wb_en2), .wb_data(wb_data2), .busy(busy2), .halted(halted2),
      .carry_flag(carry_flag2), .dbg_sel(dbg_sel2), .dbg_data(dbg_data2)
   );

   // Bench ALU: {carry, result}
   function automatic logic [8:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {a < b, a - b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         3'd5:    return {a[7], a[6:0], 1'b0};
         3'd6:    return {a[0], 1'b0, a[7:1]};
         default: return {1'b0, b};
      endcase
   endfunction

   assign {bus.alu_carry, bus.alu_result}   = alu_fn(bus.alu_sel, bus.alu_a, bus.alu_b);
   assign {bus2.alu_carry, bus2.alu_result} = alu_fn(bus2.alu_sel, bus2.alu_a, bus2.alu_b);

   logic [15:0] prog [256];
   logic [15:0] prog2 [4];
   int fixed_stall = 0, rnd_stall = 0, wait_cnt = 0, stall_now;
   bit rand_mode = 1'b0;

   assign stall_now       = rand_mode ? rnd_stall : fixed_stall;
   assign bus.imem_ack    = bus.imem_req && (wait_cnt >= stall_now);
   assign bus.imem_rdata  = prog[bus.imem_addr];
   assign bus2.imem_ack   = bus2.imem_req;
   assign bus2.imem_rdata = prog2[bus2.imem_addr];

   always @(posedge clk) begin
      if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
      else                               wait_cnt <= wait_cnt + 1;
      if (bus.imem_ack) rnd_stall <= $urandom_range(0, 2);
   end

   function automatic logic [15:0] i_loadi(input logic [1:0] rd, input logic [7:0] imm);
      return {2'b10, 3'b000, rd, 1'b0, imm};
   endfunction
   function automatic logic [15:0] i_rr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [5:0] junk);
      return {2'b00, op, rd, 1'b0, junk, rs};
   endfunction
   function automatic logic [15:0] i_ri(input logic [2:0] op, input logic [1:0] rd, input logic [7:0] imm);
      return {2'b01, op, rd, 1'b0, imm};
   endfunction
   localparam logic [15:0] I_HALT = 16'hC000;

   int n_cmp = 0, n_bad = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   logic [7:0] wbq [$];
   logic       req_q [$];
   logic [7:0] addr_q [$];
   int         wb_cycle;
   logic [7:0] exec_a, exec_b;

   task automatic run_prog(input int bound, input int again_cyc, output bit ok);
      logic [7:0] pa, pb;
      wbq.delete(); req_q.delete(); addr_q.delete();
      wb_cycle = -1; ok = 1'b0; pa = '0; pb = '0;
      @(negedge clk); start = 1'b1;
      for (int cyc = 1; cyc <= bound; cyc++) begin
         @(negedge clk);
         start = (cyc == again_cyc);
         req_q.push_back(bus.imem_req);
         addr_q.push_back(bus.imem_addr);
         if (wb_en) begin
            wbq.push_back(wb_data);
            if (wb_cycle < 0) wb_cycle = cyc;
            exec_a = pa; exec_b = pb;
         end
         if (halted) begin ok = 1'b1; break; end
         pa = bus.alu_a; pb = bus.alu_b;
      end
      start = 1'b0;
   endtask

   task automatic check_reg(input string name, input logic [1:0] r, input logic [7:0] exp);
      dbg_sel = r; #1;
      check(name, dbg_data, exp);
   endtask

   typedef struct {
      logic       is_imm;
      logic [2:0] op;
      logic [7:0] a, b, res;
      logic       c;
   } vec_t;
   vec_t vecs [10];

   logic [7:0] m_regs [4];
   logic       m_carry;
   logic [7:0] m_wb [$];
   logic [7:0] fetch2 [$];

   initial begin
      bit ok;
      vecs[0] = '{1'b0, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b1};
      vecs[1] = '{1'b0, 3'd0, 8'h01, 8'h02, 8'h03, 1'b0};
      vecs[2] = '{1'b0, 3'd1, 8'h05, 8'h07, 8'hFE, 1'b1};
      vecs[3] = '{1'b0, 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
      vecs[4] = '{1'b0, 3'd3, 8'h0F, 8'h30, 8'h3F, 1'b0};
      vecs[5] = '{1'b0, 3'd4, 8'hFF, 8'h0F, 8'hF0, 1'b0};
      vecs[6] = '{1'b0, 3'd5, 8'h81, 8'h00, 8'h02, 1'b1};
      vecs[7] = '{1'b0, 3'd6, 8'h03, 8'h00, 8'h01, 1'b1};
      vecs[8] = '{1'b1, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0};
      vecs[9] = '{1'b1, 3'd7, 8'hAA, 8'h55, 8'h55, 1'b0};
      for (int i = 0; i < 256; i++) prog[i] = I_HALT;
      for (int i = 0; i < 4; i++) prog2[i] = I_HALT;

      rst = 1'b0; start = 1'b0; start2 = 1'b0; dbg_sel = '0; dbg_sel2 = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("reset_req", bus.imem_req, 0);
      check("reset_addr", bus.imem_addr, 0);
      check("reset_busy", busy, 0);
      check("reset_halted", halted, 0);
      check("reset_wb_en", wb_en, 0);
      check("reset_carry", carry_flag, 0);
      check("reset_alu", {bus.alu_a, bus.alu_b, 5'd0, bus.alu_sel}, 0);
      check("reset_addr2", bus2.imem_addr, 3);
      for (int r = 0; r < 4; r++) check_reg($sformatf("reset_r%0d", r), r[1:0], 8'h00);

      // r0=F0, r1=20, ADD r0,r1
      prog[0] = i_loadi(2'd0, 8'hF0); prog[1] = i_loadi(2'd1, 8'h20);
      prog[2] = i_rr(3'd0, 2'd0, 2'd1, 6'd0); prog[3] = I_HALT;
      run_prog(40, -1, ok);
      check("add_halt", ok, 1);
      check("add_exec_a", exec_a, 8'hF0);
      check("add_exec_b", exec_b, 8'h20);
      check("add_carry", carry_flag, 1);
      check_reg("add_r0", 2'd0, 8'h10);
      check_reg("add_r1", 2'd1, 8'h20);

      // LOADI r1,3C; HALT -- also carry must survive a LOADI
      prog[0] = i_loadi(2'd1, 8'h3C); prog[1] = I_HALT;
      run_prog(20, -1, ok);
      check("ldi_halt", ok, 1);
      check("ldi_wb_count", wbq.size(), 1);
      if (wbq.size() > 0) check("ldi_wb_data", wbq[0], 8'h3C);
      check("ldi_wb_cycle", wb_cycle, 4);
      check("ldi_halt_addr", bus.imem_addr, 1);
      check("ldi_carry_kept", carry_flag, 1);
      check_reg("ldi_r1", 2'd1, 8'h3C);

      // Three-cycle ack stall on every fetch
      fixed_stall = 3;
      prog[0] = i_loadi(2'd0, 8'h77); prog[1] = I_HALT;
      run_prog(30, -1, ok);
      check("stall_halt", ok, 1);
      check("stall_wb_cycle", wb_cycle, 7);
      if (req_q.size() >= 5) begin
         for (int c = 0; c < 4; c++) begin
            check($sformatf("stall_req_c%0d", c + 1), req_q[c], 1);
            check($sformatf("stall_addr_c%0d", c + 1), addr_q[c], 0);
         end
         check("stall_req_decode", req_q[4], 0);
      end
      check_reg("stall_r0", 2'd0, 8'h77);
      fixed_stall = 0;

      for (int i = 0; i < 10; i++) begin
         prog[0] = i_loadi(2'd2, vecs[i].a);
         prog[1] = i_loadi(2'd3, vecs[i].b);
         prog[2] = vecs[i].is_imm ? i_ri(vecs[i].op, 2'd2, vecs[i].b) : i_rr(vecs[i].op, 2'd2, 2'd3, 6'h2A);
         prog[3] = I_HALT;
         run_prog(40, -1, ok);
         check($sformatf("vec%0d_halt", i), ok, 1);
         check($sformatf("vec%0d_wbn", i), wbq.size(), 3);
         if (wbq.size() == 3) check($sformatf("vec%0d_wb", i), wbq[2], vecs[i].res);
         check_reg($sformatf("vec%0d_rd", i), 2'd2, vecs[i].res);
         check($sformatf("vec%0d_carry", i), carry_flag, vecs[i].c);
      end

      // Asynchronous reset in the middle of a stalled fetch
      fixed_stall = 50;
      prog[0] = i_loadi(2'd0, 8'h99);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("midrst_req_before", bus.imem_req, 1);
      #2 rst = 1'b0;
      #1;
      check("midrst_req", bus.imem_req, 0);
      check("midrst_busy", busy, 0);
      check("midrst_addr", bus.imem_addr, 0);
      check("midrst_carry", carry_flag, 0);
      for (int r = 0; r < 4; r++) check_reg($sformatf("midrst_r%0d", r), r[1:0], 8'h00);
      @(negedge clk); rst = 1'b1; fixed_stall = 0;

      // start pulse while busy must be ignored
      prog[0] = i_loadi(2'd0, 8'h11); prog[1] = i_loadi(2'd1, 8'h22); prog[2] = I_HALT;
      run_prog(40, 5, ok);
      check("busy_start_halt", ok, 1);
      check("busy_start_wbn", wbq.size(), 2);
      check("busy_start_addr", bus.imem_addr, 2);

      // start in HALTED restarts at RESET_PC, registers retained
      prog[0] = I_HALT;
      run_prog(20, -1, ok);
      check("restart_halt", ok, 1);
      if (addr_q.size() > 0) check("restart_fetch_addr", addr_q[0], 0);
      check("restart_wbn", wbq.size(), 0);
      check("restart_addr", bus.imem_addr, 0);
      check_reg("restart_r0", 2'd0, 8'h11);
      check_reg("restart_r1", 2'd1, 8'h22);

      // PC wrap on the 2-bit instance starting at 3
      prog2[3] = i_loadi(2'd2, 8'hA5); prog2[0] = I_HALT;
      fetch2.delete(); dbg_sel2 = 2'd2; ok = 1'b0;
      @(negedge clk); start2 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk); start2 = 1'b0;
         if (bus2.imem_req) fetch2.push_back(8'(bus2.imem_addr));
         if (halted2) begin ok = 1'b1; break; end
      end
      check("wrap_halt", ok, 1);
      check("wrap_nfetch", fetch2.size(), 2);
      if (fetch2.size() == 2) begin
         check("wrap_fetch0", fetch2[0], 3);
         check("wrap_fetch1", fetch2[1], 0);
      end
      check("wrap_halt_addr", bus2.imem_addr, 0);
      check("wrap_r2", dbg_data2, 8'hA5);

      // Random programs with random fetch stalls against an architectural model
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
      for (int r = 0; r < 4; r++) m_regs[r] = '0;
      m_carry = 1'b0;
      rand_mode = 1'b1;
      for (int t = 0; t < 25; t++) begin
         int len;
         len = $urandom_range(1, 10);
         m_wb.delete();
         for (int i = 0; i < len; i++) begin
            logic [1:0] cls, rd, rs;
            logic [2:0] op;
            logic [7:0] imm;
            logic [8:0] r;
            cls = 2'($urandom_range(0, 2)); op = 3'($urandom); rd = 2'($urandom);
            rs = 2'($urandom); imm = 8'($urandom);
            case (cls)
               2'd0: begin
                  prog[i] = i_rr(op, rd, rs, 6'($urandom));
                  r = alu_fn(op, m_regs[rd], m_regs[rs]);
                  m_regs[rd] = r[7:0]; m_carry = r[8];
               end
               2'd1: begin
                  prog[i] = i_ri(op, rd, imm);
                  r = alu_fn(op, m_regs[rd], imm);
                  m_regs[rd] = r[7:0]; m_carry = r[8];
               end
               default: begin
                  prog[i] = i_loadi(rd, imm);
                  m_regs[rd] = imm; r = {1'b0, imm};
               end
            endcase
            m_wb.push_back(r[7:0]);
         end
         prog[len] = I_HALT;
         run_prog((len + 1) * 10, -1, ok);
         check($sformatf("rnd%0d_halt", t), ok, 1);
         check($sformatf("rnd%0d_wbn", t), wbq.size(), len);
         for (int i = 0; i < len && i < wbq.size(); i++)
            check($sformatf("rnd%0d_wb%0d", t, i), wbq[i], m_wb[i]);
         check($sformatf("rnd%0d_addr", t), bus.imem_addr, len);
         check($sformatf("rnd%0d_carry", t), carry_flag, m_carry);
         for (int r = 0; r < 4; r++) check_reg($sformatf("rnd%0d_r%0d", t, r), r[1:0], m_regs[r]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
